// File: rtl/mips_cpu_hilo_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mips_cpu_hilo_ctrl
// Brief    : HI/LO register control for DIV/DIVU/MTHI/MTLO/MFHI/MFLO with an
//            external unsigned divider and signed fix-up.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_hilo_ctrl #(
  parameter int DBZ_CLEAR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        op_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done,
  input  logic        div_dbz
);

  localparam logic [2:0] c_op_div  = 3'd0;
  localparam logic [2:0] c_op_divu = 3'd1;
  localparam logic [2:0] c_op_mthi = 3'd2;
  localparam logic [2:0] c_op_mtlo = 3'd3;
  localparam logic [2:0] c_op_mfhi = 3'd4;
  localparam logic [2:0] c_op_mflo = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_FIX   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_sign_a;
  logic        r_sign_b;
  logic        w_accept;
  logic        w_is_div;
  logic        w_sign_a;
  logic        w_sign_b;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_start_div;
  logic [31:0] w_fix_q;
  logic [31:0] w_fix_r;
  logic        w_unused;

  // Divide-by-zero is detected from op_b locally, so the divider flag is unused.
  assign w_unused    = div_dbz;

  assign op_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign div_start   = (r_state == S_START);

  assign w_accept    = op_valid & op_ready & ~flush;
  assign w_is_div    = (op_code == c_op_div) || (op_code == c_op_divu);
  assign w_sign_a    = (op_code == c_op_div) & op_a[31];
  assign w_sign_b    = (op_code == c_op_div) & op_b[31];
  assign w_mag_a     = w_sign_a ? (~op_a + 32'd1) : op_a;
  assign w_mag_b     = w_sign_b ? (~op_b + 32'd1) : op_b;
  assign w_start_div = w_accept & w_is_div & (op_b != 32'd0) & (w_mag_a != 32'd0);

  assign w_fix_q     = (r_sign_a ^ r_sign_b) ? (~div_quotient + 32'd1) : div_quotient;
  assign w_fix_r     = r_sign_a ? (~div_remainder + 32'd1) : div_remainder;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_div) w_next = S_START;
      S_START: w_next = flush ? S_IDLE : S_WAIT;
      S_WAIT: begin
        if (flush)         w_next = S_IDLE;
        else if (div_done) w_next = S_FIX;
      end
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi           <= 32'd0;
      lo           <= 32'd0;
      rd_data      <= 32'd0;
      rd_valid     <= 1'b0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
      r_sign_a     <= 1'b0;
      r_sign_b     <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (w_accept) begin
        case (op_code)
          c_op_div, c_op_divu: begin
            if (op_b == 32'd0) begin
              if (DBZ_CLEAR != 0) begin
                hi <= 32'd0;
                lo <= 32'd0;
              end
            end else if (w_mag_a == 32'd0) begin
              hi <= 32'd0;
              lo <= 32'd0;
            end else begin
              r_sign_a     <= w_sign_a;
              r_sign_b     <= w_sign_b;
              div_dividend <= w_mag_a;
              div_divisor  <= w_mag_b;
            end
          end
          c_op_mthi: hi <= op_a;
          c_op_mtlo: lo <= op_a;
          c_op_mfhi: begin
            rd_data  <= hi;
            rd_valid <= 1'b1;
          end
          c_op_mflo: begin
            rd_data  <= lo;
            rd_valid <= 1'b1;
          end
          default: ;
        endcase
      end
      // Flush arriving in FIX still wins: the result is discarded.
      if ((r_state == S_FIX) && !flush) begin
        lo <= w_fix_q;
        hi <= w_fix_r;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_hilo_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mips_cpu_hilo_ctrl
// Brief    : Directed self-checking bench with a 32-cycle behavioural divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_hilo_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        flush = 1'b0;
  logic        op_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient = 32'd0;
  logic [31:0] div_remainder = 32'd0;
  logic        div_done = 1'b0;
  logic        div_dbz = 1'b0;

  int total = 0;
  int bad = 0;
  int starts = 0;
  int m_cnt = 0;

  mips_cpu_hilo_ctrl #(.DBZ_CLEAR(0)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .flush(flush), .op_ready(op_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .hi(hi), .lo(lo), .busy(busy),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_done(div_done), .div_dbz(div_dbz)
  );

  always #5 clk = ~clk;

  // Divider model: done appears 32 edges after the start edge, held until next start.
  always @(posedge clk) begin
    if (div_start) begin
      m_cnt    <= 32;
      div_done <= 1'b0;
      if (div_divisor != 32'd0) begin
        div_quotient  <= div_dividend / div_divisor;
        div_remainder <= div_dividend % div_divisor;
      end
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) div_done <= 1'b1;
    end
  end

  always @(negedge clk) if (div_start) starts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid = 1'b0;
  endtask

  // Called in C+1; returns the cycle index (relative to C) where op_ready is first seen.
  task automatic wait_ready(output int n);
    n = 1;
    while (!op_ready && n < 80) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    op_valid = 1'b1;
    op_code  = 3'd2;
    op_a     = 32'h99;
    tick();
    tick();
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    total++; if (rd_data !== 32'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd: got %h/%b want 0/0", rd_data, rd_valid); end
    total++; if (div_start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_ctl: start=%b busy=%b want 0/0", div_start, busy); end
    total++; if (div_dividend !== 32'd0 || div_divisor !== 32'd0) begin bad++; $display("FAIL reset_div: got %h/%h want 0/0", div_dividend, div_divisor); end
    op_valid = 1'b0;
    reset    = 1'b1;
    total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", op_ready); end
  endtask

  task automatic test_div_vectors();
    logic [2:0]  v_op  [6] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0};
    logic [31:0] v_a   [6] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'h80000000, 32'd100, 32'hFFFFFF9C};
    logic [31:0] v_b   [6] = '{32'hFFFFFFFE, 32'd2, 32'd16, 32'hFFFFFFFF, 32'd7, 32'hFFFFFFF9};
    logic [31:0] v_ma  [6] = '{32'd7, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'd100, 32'd100};
    logic [31:0] v_mb  [6] = '{32'd2, 32'd2, 32'd16, 32'd1, 32'd7, 32'd7};
    logic [31:0] v_lo  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h0FFFFFFF, 32'h80000000, 32'd14, 32'd14};
    logic [31:0] v_hi  [6] = '{32'd1, 32'hFFFFFFFF, 32'hF, 32'd0, 32'd2, 32'hFFFFFFFE};
    int n;
    for (int i = 0; i < 6; i++) begin
      issue(v_op[i], v_a[i], v_b[i]);
      total++; if (div_start !== 1'b1 || op_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL div%0d_start: start=%b ready=%b busy=%b want 1/0/1", i, div_start, op_ready, busy); end
      total++; if (div_dividend !== v_ma[i] || div_divisor !== v_mb[i]) begin bad++; $display("FAIL div%0d_mag: got %h/%h want %h/%h", i, div_dividend, div_divisor, v_ma[i], v_mb[i]); end
      tick();
      total++; if (div_start !== 1'b0) begin bad++; $display("FAIL div%0d_pulse: start=%b in C+2 want 0", i, div_start); end
      n = 2;
      while (!op_ready && n < 80) begin tick(); n++; end
      total++; if (n !== 36) begin bad++; $display("FAIL div%0d_latency: ready at C+%0d want C+36", i, n); end
      total++; if (lo !== v_lo[i] || hi !== v_hi[i]) begin bad++; $display("FAIL div%0d_result: lo=%h hi=%h want %h/%h", i, lo, hi, v_lo[i], v_hi[i]); end
    end
  endtask

  task automatic test_zero_dividend();
    int s0;
    issue(3'd2, 32'h33, 32'd0);
    issue(3'd3, 32'h44, 32'd0);
    s0 = starts;
    issue(3'd1, 32'd0, 32'd5);
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL zero_div_hilo: hi=%h lo=%h want 0/0", hi, lo); end
    total++; if (op_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_div_ready: ready=%b busy=%b want 1/0", op_ready, busy); end
    repeat (3) tick();
    total++; if (starts !== s0) begin bad++; $display("FAIL zero_div_nostart: starts=%0d want %0d", starts, s0); end
  endtask

  task automatic test_mt_dbz();
    int s0;
    issue(3'd2, 32'h11, 32'd0);
    total++; if (hi !== 32'h11) begin bad++; $display("FAIL mthi: hi=%h want 11", hi); end
    issue(3'd3, 32'h22, 32'd0);
    total++; if (lo !== 32'h22) begin bad++; $display("FAIL mtlo: lo=%h want 22", lo); end
    s0 = starts;
    issue(3'd0, 32'h1234, 32'd0);
    total++; if (op_ready !== 1'b1 || hi !== 32'h11 || lo !== 32'h22) begin bad++; $display("FAIL dbz: ready=%b hi=%h lo=%h want 1/11/22", op_ready, hi, lo); end
    repeat (3) tick();
    total++; if (starts !== s0) begin bad++; $display("FAIL dbz_nostart: starts=%0d want %0d", starts, s0); end
    issue(3'd7, 32'hDEAD, 32'd3);
    total++; if (op_ready !== 1'b1 || hi !== 32'h11 || lo !== 32'h22 || rd_valid !== 1'b0) begin bad++; $display("FAIL reserved: ready=%b hi=%h lo=%h rdv=%b want 1/11/22/0", op_ready, hi, lo, rd_valid); end
  endtask

  task automatic test_mf_stall();
    int n;
    issue(3'd0, 32'd100, 32'd7);
    op_valid = 1'b1;
    op_code  = 3'd5;
    n = 1;
    while (!op_ready && n < 80) begin tick(); n++; end
    total++; if (n !== 36) begin bad++; $display("FAIL mf_stall_ready: ready at C+%0d want C+36", n); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mf_stall_early: rd_valid=%b want 0", rd_valid); end
    tick();
    op_valid = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 32'd14) begin bad++; $display("FAIL mf_stall_rd: rdv=%b data=%h want 1/0000000e", rd_valid, rd_data); end
    tick();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL mf_pulse: rd_valid=%b want 0", rd_valid); end
    issue(3'd4, 32'd0, 32'd0);
    total++; if (rd_valid !== 1'b1 || rd_data !== 32'd2) begin bad++; $display("FAIL mfhi: rdv=%b data=%h want 1/2", rd_valid, rd_data); end
  endtask

  task automatic test_flush();
    int n;
    issue(3'd2, 32'hAA, 32'd0);
    issue(3'd3, 32'hBB, 32'd0);
    issue(3'd0, 32'd9, 32'd2);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (busy !== 1'b0 || op_ready !== 1'b1) begin bad++; $display("FAIL flush_idle: busy=%b ready=%b want 0/1", busy, op_ready); end
    total++; if (hi !== 32'hAA || lo !== 32'hBB) begin bad++; $display("FAIL flush_hilo: hi=%h lo=%h want aa/bb", hi, lo); end
    repeat (30) tick();
    total++; if (hi !== 32'hAA || lo !== 32'hBB || busy !== 1'b0) begin bad++; $display("FAIL flush_residue: hi=%h lo=%h busy=%b want aa/bb/0", hi, lo, busy); end
    issue(3'd0, 32'hFFFFFFF7, 32'd4);
    wait_ready(n);
    total++; if (n !== 36) begin bad++; $display("FAIL after_flush_latency: ready at C+%0d want C+36", n); end
    total++; if (lo !== 32'hFFFFFFFE || hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL after_flush_result: lo=%h hi=%h want fffffffe/ffffffff", lo, hi); end
    flush = 1'b1;
    issue(3'd2, 32'h55, 32'd0);
    flush = 1'b0;
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL idle_flush_block: hi=%h want ffffffff", hi); end
  endtask

  task automatic test_reset_mid();
    issue(3'd0, 32'd7, 32'hFFFFFFFE);
    repeat (19) tick();
    reset = 1'b0;
    tick();
    total++; if (hi !== 32'd0 || lo !== 32'd0 || rd_data !== 32'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL midreset_regs: hi=%h lo=%h rd=%h rdv=%b want all 0", hi, lo, rd_data, rd_valid); end
    total++; if (busy !== 1'b0 || div_start !== 1'b0 || div_dividend !== 32'd0 || div_divisor !== 32'd0) begin bad++; $display("FAIL midreset_ctl: busy=%b start=%b dd=%h dv=%h want all 0", busy, div_start, div_dividend, div_divisor); end
    reset = 1'b1;
    total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: ready=%b want 1", op_ready); end
    repeat (40) tick();
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin bad++; $display("FAIL midreset_abandon: hi=%h lo=%h want 0/0", hi, lo); end
  endtask

  initial begin
    #1;
    test_reset();
    test_div_vectors();
    test_zero_dividend();
    test_mt_dbz();
    test_mf_stall();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
